// File: rtl/pipe_reg_skid.sv
// Registered pipeline stage with a one-entry skid buffer: full throughput with
// registered in_ready, plus flush, occupancy report and a saturating stall counter.
module pipe_reg_skid #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] PRESET_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept, pop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Handshake outputs decode only the state register, so nothing combinational
    // from the inputs reaches in_ready or out_valid.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = cnt_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = PRESET_VAL;
            skid_d  = PRESET_VAL;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = HALF;
                        main_d  = in_data;
                    end
                end
                HALF: begin
                    if (accept && pop) begin
                        main_d = in_data;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d = HALF;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stall accounting runs independently of flush.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (out_valid && !out_ready) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= EMPTY;
            main_q  <= PRESET_VAL;
            skid_q  <= PRESET_VAL;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
